// File: rtl/pixel_pkg.sv
// -----------------------------------------------------------------------------
// pixel_pkg
// Shared definitions for the pixel SRAM word format and the raster address
// layout. The SRAM init stage packs words with pack_coords(); the frame-scan
// reader unpacks them with decode_word(), so both sides agree on bit positions.
//
// Contents:
//   DEF_WIDTH / DEF_HEIGHT   default frame geometry
//   Address layout           {y[Y_BITS-1:0], x[X_BITS-1:0]}, y starts at Y_LSB
//   Word layout              bit 15 done flag, 14:7 x field, 6:0 y field
//   pixel_word_t             raw 16-bit SRAM word
//   pixel_result_t           decoded {done, count, x, y}
// -----------------------------------------------------------------------------
package pixel_pkg;

  localparam int DEF_WIDTH  = 800;
  localparam int DEF_HEIGHT = 480;

  localparam int ADDR_W = 19;
  localparam int Y_LSB  = 10;
  localparam int X_BITS = 10;
  localparam int Y_BITS = ADDR_W - Y_LSB;

  localparam int WORD_W      = 16;
  localparam int DONE_BIT    = 15;
  localparam int X_FIELD_MSB = 14;
  localparam int X_FIELD_LSB = 7;
  localparam int Y_FIELD_MSB = 6;
  localparam int Y_FIELD_LSB = 0;
  localparam int X_FIELD_W   = X_FIELD_MSB - X_FIELD_LSB + 1;
  localparam int Y_FIELD_W   = Y_FIELD_MSB - Y_FIELD_LSB + 1;

  localparam int COORD_W = 18;
  localparam int COUNT_W = 15;

  typedef struct packed {
    logic                 done;
    logic [X_FIELD_W-1:0] xf;
    logic [Y_FIELD_W-1:0] yf;
  } pixel_word_t;

  typedef struct packed {
    logic               done;
    logic [COUNT_W-1:0] count;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } pixel_result_t;

  // The coordinate fields hold the top bits of an 18-bit two's complement
  // value, so the sign lands in bit 17 and the dropped low bits read as zero.
  function automatic pixel_result_t decode_word(input pixel_word_t w);
    logic [WORD_W-1:0] b;
    pixel_result_t     r;
    b       = w;
    r.done  = b[DONE_BIT];
    r.count = b[COUNT_W-1:0];
    r.x     = {b[X_FIELD_MSB:X_FIELD_LSB], {(COORD_W - X_FIELD_W){1'b0}}};
    r.y     = {b[Y_FIELD_MSB:Y_FIELD_LSB], {(COORD_W - Y_FIELD_W){1'b0}}};
    return r;
  endfunction

  // Packing used by the init stage: keeps only the coordinate MSBs.
  function automatic pixel_word_t pack_coords(input logic [COORD_W-1:0] x,
                                              input logic [COORD_W-1:0] y);
    pixel_word_t w;
    w.done = 1'b0;
    w.xf   = x[COORD_W-1 -: X_FIELD_W];
    w.yf   = y[COORD_W-1 -: Y_FIELD_W];
    return w;
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// -----------------------------------------------------------------------------
// pixel_fifo
// Synchronous FIFO with simultaneous push/pop and an occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
//
// Ports:
//   i_Clk, i_Rst_n   clock, asynchronous active-low reset
//   i_Push, i_Data   write strobe / data (ignored when full)
//   i_Pop            read strobe (ignored when empty)
//   o_Data           head entry (valid when o_Empty = 0)
//   o_Empty          no entries stored
//   o_Count          number of stored entries
// -----------------------------------------------------------------------------
module pixel_fifo #(
  parameter int DW    = 35,
  parameter int DEPTH = 4
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst_n,
  input  logic                       i_Push,
  input  logic [DW-1:0]              i_Data,
  input  logic                       i_Pop,
  output logic [DW-1:0]              o_Data,
  output logic                       o_Empty,
  output logic [$clog2(DEPTH):0]     o_Count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign push_ok = i_Push & (count_q != (AW+1)'(DEPTH));
  assign pop_ok  = i_Pop & (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    // Push and pop together leave the count unchanged.
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; emptiness is tracked by the count alone.
  always_ff @(posedge i_Clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_Data;
  end

  assign o_Data  = mem_q[rd_ptr_q];
  assign o_Empty = (count_q == '0);
  assign o_Count = count_q;

endmodule

// File: rtl/sram_pixel_reader.sv
// -----------------------------------------------------------------------------
// sram_pixel_reader
// Walks every pixel address of a frame in raster order, issues pipelined SRAM
// reads, decodes each returned word and streams {address, decoded word} to the
// iteration engine over valid/ready.
//
// Ports:
//   i_Clk, i_Rst_n     clock, asynchronous active-low reset
//   i_Start            one-cycle pulse, starts a frame scan when idle
//   o_Busy             frame in progress (low in the o_Frame_Done cycle)
//   o_Rd_En/o_Rd_Addr  SRAM read strobe and address {y, x}
//   i_Rd_Data          SRAM data, RD_LAT cycles after the strobe
//   o_Valid/i_Ready    result handshake
//   o_Addr             pixel address of the result
//   o_Done/o_Count     finished flag and iteration count
//   o_X/o_Y            signed 18-bit start coordinates
//   o_Frame_Done       pulse when the last result has been accepted
// -----------------------------------------------------------------------------
module sram_pixel_reader
  import pixel_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int HEIGHT     = DEF_HEIGHT,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_Start,
  output logic        o_Busy,
  output logic        o_Rd_En,
  output logic [18:0] o_Rd_Addr,
  input  logic [15:0] i_Rd_Data,
  output logic        o_Valid,
  input  logic        i_Ready,
  output logic [18:0] o_Addr,
  output logic        o_Done,
  output logic [14:0] o_Count,
  output logic [17:0] o_X,
  output logic [17:0] o_Y,
  output logic        o_Frame_Done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 2;
  localparam int FW = ADDR_W + WORD_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [X_BITS-1:0] X_LAST = X_BITS'(WIDTH - 1);
  localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(HEIGHT - 1);

  logic [1:0]        state_q, state_d;
  logic [X_BITS-1:0] x_q, x_d;
  logic [Y_BITS-1:0] y_q, y_d;
  logic [CW-1:0]     inflight_q, inflight_d;
  logic [RD_LAT-1:0] dly_vld_q;
  logic [ADDR_W-1:0] dly_addr_q [RD_LAT];

  logic              rd_en, last_addr, frame_done;
  logic              push, pop, fifo_empty;
  logic [AW:0]       fifo_count;
  logic [FW-1:0]     fifo_head;
  logic [CW-1:0]     occupancy;
  logic [ADDR_W-1:0] rd_addr;
  pixel_result_t     res;

  // Credit check: every issued read already owns a FIFO slot, and a slot being
  // popped this cycle can be reused immediately.
  assign pop       = ~fifo_empty & i_Ready;
  assign push      = dly_vld_q[RD_LAT-1];
  assign occupancy = inflight_q + CW'(fifo_count) - CW'(pop);
  assign rd_en     = (state_q == S_SCAN) && (occupancy < CW'(FIFO_DEPTH));
  assign last_addr = (x_q == X_LAST) && (y_q == Y_LAST);
  assign frame_done = (state_q == S_DRAIN) && (inflight_q == '0) && fifo_empty;

  assign rd_addr[ADDR_W-1:Y_LSB] = y_q;
  assign rd_addr[Y_LSB-1:0]      = x_q;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    inflight_d = inflight_q + CW'(rd_en) - CW'(push);
    case (state_q)
      S_IDLE: begin
        if (i_Start) begin
          state_d = S_SCAN;
          x_d     = '0;
          y_d     = '0;
        end
      end
      S_SCAN: begin
        if (rd_en) begin
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = last_addr ? '0 : y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
          if (last_addr) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (frame_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      inflight_q <= inflight_d;
    end
  end

  // Read-latency delay line: clearing the strobes on reset drops any read
  // still in flight, so its returning data is never pushed.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      dly_vld_q <= '0;
    end else begin
      dly_vld_q[0] <= rd_en;
      for (int i = 1; i < RD_LAT; i++) dly_vld_q[i] <= dly_vld_q[i-1];
    end
  end

  always_ff @(posedge i_Clk) begin
    dly_addr_q[0] <= rd_addr;
    for (int i = 1; i < RD_LAT; i++) dly_addr_q[i] <= dly_addr_q[i-1];
  end

  pixel_fifo #(
    .DW    (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_Push  (push),
    .i_Data  ({dly_addr_q[RD_LAT-1], i_Rd_Data}),
    .i_Pop   (pop),
    .o_Data  (fifo_head),
    .o_Empty (fifo_empty),
    .o_Count (fifo_count)
  );

  assign res = decode_word(pixel_word_t'(fifo_head[WORD_W-1:0]));

  assign o_Busy       = (state_q != S_IDLE) & ~frame_done;
  assign o_Rd_En      = rd_en;
  assign o_Rd_Addr    = rd_addr;
  assign o_Frame_Done = frame_done;
  assign o_Valid      = ~fifo_empty;

  // Result fields are forced to zero when nothing is held, so stale FIFO
  // storage never reaches the outputs (including right after reset).
  assign o_Addr  = fifo_empty ? '0 : fifo_head[FW-1:WORD_W];
  assign o_Done  = fifo_empty ? 1'b0 : res.done;
  assign o_Count = fifo_empty ? '0 : res.count;
  assign o_X     = fifo_empty ? '0 : res.x;
  assign o_Y     = fifo_empty ? '0 : res.y;

endmodule

// File: tb/tb_sram_pixel_reader.sv
module tb_sram_pixel_reader;

  localparam int W     = 5;
  localparam int H     = 3;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int N     = W * H;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        rd_en;
  logic [18:0] rd_addr;
  logic [15:0] rd_data;
  logic        valid;
  logic        ready;
  logic [18:0] addr;
  logic        done;
  logic [14:0] count;
  logic [17:0] xo;
  logic [17:0] yo;
  logic        frame_done;

  int checks;
  int failures;

  logic [15:0] mem0;
  logic        en1, en2;
  logic [18:0] a1, a2;

  sram_pixel_reader #(
    .WIDTH      (W),
    .HEIGHT     (H),
    .RD_LAT     (LAT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .i_Clk        (clk),
    .i_Rst_n      (rst_n),
    .i_Start      (start),
    .o_Busy       (busy),
    .o_Rd_En      (rd_en),
    .o_Rd_Addr    (rd_addr),
    .i_Rd_Data    (rd_data),
    .o_Valid      (valid),
    .i_Ready      (ready),
    .o_Addr       (addr),
    .o_Done       (done),
    .o_Count      (count),
    .o_X          (xo),
    .o_Y          (yo),
    .o_Frame_Done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] word_of(input logic [18:0] a, input logic [15:0] w0);
    int v;
    if (a == 19'd0) return w0;
    v = (int'(a) * 40503) ^ 23130;
    return v[15:0];
  endfunction

  function automatic logic [18:0] addr_of(input int idx);
    logic [8:0] yy;
    logic [9:0] xx;
    yy = 9'(idx / W);
    xx = 10'(idx % W);
    return {yy, xx};
  endfunction

  // SRAM model with a two-cycle read pipeline.
  always @(posedge clk) begin
    en1 <= rd_en;
    a1  <= rd_addr;
    en2 <= en1;
    a2  <= a1;
  end
  assign rd_data = en2 ? word_of(a2, mem0) : 16'h0000;

  function automatic logic pick_ready(input int low_pct);
    return ($urandom_range(99) < low_pct) ? 1'b0 : 1'b1;
  endfunction

  task automatic check_all_zero(input string tag);
    checks++;
    if (busy !== 1'b0 || rd_en !== 1'b0 || rd_addr !== 19'd0 || valid !== 1'b0 ||
        addr !== 19'd0 || done !== 1'b0 || count !== 15'd0 || xo !== 18'd0 ||
        yo !== 18'd0 || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL %s: busy=%b rd_en=%b rd_addr=%h valid=%b addr=%h done=%b count=%h x=%h y=%h fd=%b, required all 0",
               tag, busy, rd_en, rd_addr, valid, addr, done, count, xo, yo, frame_done);
    end
  endtask

  // Runs one frame from an i_Start pulse, checking every accepted result,
  // handshake stability, busy, read addresses and outstanding-read bound.
  task automatic run_frame(input int low_pct, input bit extra_start,
                           output int first_cyc, output int done_cyc,
                           output int nres, output int ndone,
                           output logic f_done, output logic [14:0] f_cnt,
                           output logic [17:0] f_x, output logic [17:0] f_y);
    int          c, idx, outstanding;
    bit          stalled;
    logic [18:0] s_addr;
    logic        s_done;
    logic [14:0] s_cnt;
    logic [17:0] s_x, s_y;
    logic [15:0] w;
    first_cyc = -1; done_cyc = -1; nres = 0; ndone = 0;
    idx = 0; outstanding = 0; stalled = 0;
    f_done = 1'b0; f_cnt = '0; f_x = '0; f_y = '0;
    s_addr = '0; s_done = 1'b0; s_cnt = '0; s_x = '0; s_y = '0;
    @(posedge clk); #1;
    start = 1'b1;
    ready = pick_ready(low_pct);
    c = 0;
    while (ndone == 0 && c < 400) begin
      @(posedge clk); #1;
      c++;
      start = extra_start && (c == 3 || c == 7 || c == 12);
      ready = pick_ready(low_pct);
      @(negedge clk);
      checks++;
      if (busy !== !frame_done) begin
        failures++;
        $display("FAIL busy cycle %0d: got %b, required %b", c, busy, !frame_done);
      end
      if (rd_en) begin
        outstanding++;
        checks++;
        if (rd_addr[9:0] >= 10'(W) || rd_addr[18:10] >= 9'(H)) begin
          failures++;
          $display("FAIL rd_addr range cycle %0d: got %h", c, rd_addr);
        end
      end
      if (stalled) begin
        checks++;
        if (valid !== 1'b1 || addr !== s_addr || done !== s_done || count !== s_cnt ||
            xo !== s_x || yo !== s_y) begin
          failures++;
          $display("FAIL stall hold cycle %0d: valid=%b addr=%h x=%h y=%h, required 1 %h %h %h",
                   c, valid, addr, xo, yo, s_addr, s_x, s_y);
        end
      end
      if (valid && first_cyc < 0) begin
        first_cyc = c;
        f_done = done; f_cnt = count; f_x = xo; f_y = yo;
      end
      if (valid && ready) begin
        w = word_of(addr_of(idx), mem0);
        checks++;
        if (idx >= N || addr !== addr_of(idx) || done !== w[15] || count !== w[14:0] ||
            xo !== {w[14:7], 10'b0} || yo !== {w[6:0], 11'b0}) begin
          failures++;
          $display("FAIL result %0d: addr=%h done=%b count=%h x=%h y=%h, required addr=%h word=%h",
                   idx, addr, done, count, xo, yo, addr_of(idx), w);
        end
        idx++; nres++; outstanding--;
      end
      checks++;
      if (outstanding > DEPTH) begin
        failures++;
        $display("FAIL outstanding cycle %0d: got %0d, required <= %0d", c, outstanding, DEPTH);
      end
      stalled = valid && !ready;
      s_addr = addr; s_done = done; s_cnt = count; s_x = xo; s_y = yo;
      if (frame_done) begin
        ndone++;
        done_cyc = c;
      end
    end
    if (ndone == 0) begin
      failures++;
      $display("FAIL frame timeout: no frame done after %0d cycles", c);
    end
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      ready = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || frame_done !== 1'b0 || valid !== 1'b0 || rd_en !== 1'b0) begin
        failures++;
        $display("FAIL post-frame idle %0d: busy=%b fd=%b valid=%b rd_en=%b, required 0",
                 k, busy, frame_done, valid, rd_en);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset state");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("after reset release");
  endtask

  task automatic test_single_word();
    int fc, dc, nr, nd;
    logic fdn; logic [14:0] fcn; logic [17:0] fx, fy;
    mem0 = 16'h7FFF;
    run_frame(0, 1'b0, fc, dc, nr, nd, fdn, fcn, fx, fy);
    checks++;
    if (fc !== LAT + 2) begin failures++; $display("FAIL first latency: got %0d, required %0d", fc, LAT + 2); end
    checks++;
    if (dc !== N + LAT + 2) begin failures++; $display("FAIL frame done cycle: got %0d, required %0d", dc, N + LAT + 2); end
    checks++;
    if (nr !== N || nd !== 1) begin failures++; $display("FAIL full frame counts: results=%0d dones=%0d, required %0d 1", nr, nd, N); end
    checks++;
    if (fdn !== 1'b0 || fx !== 18'h3FC00 || fy !== 18'h3F800) begin
      failures++;
      $display("FAIL word 7FFF: done=%b x=%h y=%h, required 0 3fc00 3f800", fdn, fx, fy);
    end
  endtask

  task automatic test_done_word();
    int fc, dc, nr, nd;
    logic fdn; logic [14:0] fcn; logic [17:0] fx, fy;
    mem0 = 16'h8123;
    run_frame(0, 1'b0, fc, dc, nr, nd, fdn, fcn, fx, fy);
    checks++;
    if (fdn !== 1'b1 || fcn !== 15'h0123) begin
      failures++;
      $display("FAIL word 8123 done/count: got %b %h, required 1 0123", fdn, fcn);
    end
    checks++;
    if (fx !== 18'h00800 || fy !== 18'h11800) begin
      failures++;
      $display("FAIL word 8123 x/y: got %h %h, required 00800 11800", fx, fy);
    end
  endtask

  task automatic test_backpressure();
    int fc, dc, nr, nd;
    logic fdn; logic [14:0] fcn; logic [17:0] fx, fy;
    mem0 = 16'h1234;
    run_frame(30, 1'b0, fc, dc, nr, nd, fdn, fcn, fx, fy);
    checks++;
    if (nr !== N || nd !== 1) begin failures++; $display("FAIL backpressure counts: results=%0d dones=%0d, required %0d 1", nr, nd, N); end
    checks++;
    if (dc < N + LAT + 2) begin failures++; $display("FAIL backpressure done cycle: got %0d, required >= %0d", dc, N + LAT + 2); end
  endtask

  task automatic test_start_during_scan();
    int fc, dc, nr, nd;
    logic fdn; logic [14:0] fcn; logic [17:0] fx, fy;
    mem0 = 16'h0F0F;
    run_frame(0, 1'b1, fc, dc, nr, nd, fdn, fcn, fx, fy);
    checks++;
    if (nr !== N || nd !== 1 || dc !== N + LAT + 2) begin
      failures++;
      $display("FAIL restart ignored: results=%0d dones=%0d done_cycle=%0d, required %0d 1 %0d",
               nr, nd, dc, N, N + LAT + 2);
    end
  endtask

  task automatic test_reset_mid_frame();
    int fc, dc, nr, nd;
    logic fdn; logic [14:0] fcn; logic [17:0] fx, fy;
    mem0 = 16'hABCD;
    ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    checks++;
    if (valid !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL mid-frame before reset: valid=%b busy=%b, required 1 1", valid, busy);
    end
    rst_n = 1'b0;
    #1;
    check_all_zero("async reset mid-frame");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem0 = 16'h4321;
    run_frame(0, 1'b0, fc, dc, nr, nd, fdn, fcn, fx, fy);
    checks++;
    if (fc !== LAT + 2 || nr !== N || nd !== 1) begin
      failures++;
      $display("FAIL after reset frame: first=%0d results=%0d dones=%0d, required %0d %0d 1",
               fc, nr, nd, LAT + 2, N);
    end
    checks++;
    if (fdn !== 1'b0 || fcn !== 15'h4321 || fx !== 18'h21800 || fy !== 18'h10800) begin
      failures++;
      $display("FAIL after reset first word: done=%b count=%h x=%h y=%h, required 0 4321 21800 10800",
               fdn, fcn, fx, fy);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    ready    = 1'b0;
    mem0     = 16'h0000;
    test_reset();
    test_single_word();
    test_done_word();
    test_backpressure();
    test_start_during_scan();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
